// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide synchronous RAM with one-cycle registered reads.
// Sub-word stores use read-modify-write. Define MAU_BIG_ENDIAN_EN for big-endian lane mapping.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic                    i_wr,
    input  logic [1:0]              i_size,
    input  logic                    i_sign,
    input  logic [ADDR_WIDTH+1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_ram_we,
    output logic                    o_ram_oe,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]   i_ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RCAP,
        S_WR,
        S_RMW_RD,
        S_RMW_CAP,
        S_RMW_WR,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    sign_q, sign_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ram_we_q, ram_we_d;
    logic                    ram_oe_q, ram_oe_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

    logic                    req_err;
    logic [1:0]              lane_lo;
    logic [3:0]              byte_en;
    logic [DATA_WIDTH-1:0]   rdata_shift;
    logic [DATA_WIDTH-1:0]   wdata_shift;
    logic [DATA_WIDTH-1:0]   load_value;
    logic [DATA_WIDTH-1:0]   merged_word;

    always_comb begin
        req_err = 1'b0;
        case (i_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = i_addr[0];
            2'b10:   req_err = (i_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // lane_lo is the lowest byte lane touched by the latched access.
    always_comb begin
        lane_lo = 2'd0;
        case (size_q)
`ifdef MAU_BIG_ENDIAN_EN
            2'b00:   lane_lo = ~off_q;
            2'b01:   lane_lo = off_q[1] ? 2'd0 : 2'd2;
`else
            2'b00:   lane_lo = off_q;
            2'b01:   lane_lo = {off_q[1], 1'b0};
`endif
            default: lane_lo = 2'd0;
        endcase
    end

    always_comb begin
        byte_en = 4'b1111;
        case (size_q)
            2'b00:   byte_en = 4'b0001 << lane_lo;
            2'b01:   byte_en = 4'b0011 << lane_lo;
            default: byte_en = 4'b1111;
        endcase
    end

    assign rdata_shift = i_ram_rdata >> {lane_lo, 3'b000};
    assign wdata_shift = wdata_q << {lane_lo, 3'b000};

    always_comb begin
        load_value = i_ram_rdata;
        case (size_q)
            2'b00: load_value = {{(DATA_WIDTH-8){sign_q & rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01: load_value = {{(DATA_WIDTH-16){sign_q & rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_value = i_ram_rdata;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = byte_en[gi] ? wdata_shift[8*gi +: 8]
                                                        : i_ram_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        sign_d      = sign_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        ram_we_d    = 1'b0;
        ram_oe_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    off_d   = i_addr[1:0];
                    size_d  = i_size;
                    sign_d  = i_sign;
                    wdata_d = i_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = S_DONE;
                    end else begin
                        ram_addr_d = i_addr[ADDR_WIDTH+1:2];
                        if (!i_wr) begin
                            state_d  = S_RD;
                            ram_oe_d = 1'b1;
                        end else if (i_size == 2'b10) begin
                            state_d     = S_WR;
                            ram_we_d    = 1'b1;
                            ram_wdata_d = i_wdata;
                        end else begin
                            state_d  = S_RMW_RD;
                            ram_oe_d = 1'b1;
                        end
                    end
                end
            end
            S_RD:      state_d = S_RCAP;
            S_RCAP: begin
                rdata_d = load_value;
                state_d = S_DONE;
            end
            S_WR:      state_d = S_DONE;
            S_RMW_RD:  state_d = S_RMW_CAP;
            S_RMW_CAP: begin
                state_d     = S_RMW_WR;
                ram_we_d    = 1'b1;
                ram_wdata_d = merged_word;
            end
            S_RMW_WR:  state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            off_q       <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_err       = (state_q == S_DONE) & err_q;
    assign o_rdata     = rdata_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_oe    = ram_oe_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;

endmodule
